vliw_packer: RTL and testbench
==============================

Name: vliw_packer

Overview:
Packs a stream of single instructions into very long instruction words, one slot per core. It is the write-side counterpart of the VLIW splitter: the packer's bundles feed instruction memory or the fetch path, and the splitter later breaks them back into per-core instructions. Slot ordering matches the splitter. Input and output use valid/ready handshakes, and the block holds one output bundle.

Parameters:
cores, 4, number of cores = instruction slots per VLIW
inst_len, 32, bits per instruction
NOP, 0 (inst_len bits), pad value for unused slots
TIMEOUT, 8, idle cycles before a partial-bundle flush (used only with the optional feature)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous reset, active-high
in_valid  input  1  in_inst is valid
in_ready  output  1  packer accepts in_inst this cycle
in_inst  input  inst_len  instruction
in_last  input  1  in_inst closes the current bundle; remaining slots are padded
out_valid  output  1  out_vliw holds a complete bundle
out_ready  input  1  consumer takes out_vliw this cycle
out_vliw  output  inst_len*cores  bundle; slot i = bits [inst_len*(i+1)-1 : inst_len*i]
out_count  output  clog2(cores+1)  number of real (non-pad) instructions in out_vliw

Behaviour:
- Reset (sync, high) drives:
  - out_valid=0, out_vliw all NOP, out_count=0.
  - Fill counter=0 and assembly slots all NOP.
  - Idle counter=0.
  - Any partial bundle or pending output is discarded, including mid-bundle.
- in_ready = !out_valid || out_ready. This is combinational from out_ready and independent of in_valid, in_last and fill.
- Accept = in_valid && in_ready.
- First instruction of a bundle goes to slot 0; fill counter ranges 0..cores-1.
- Accept without completion (fill < cores-1 and !in_last):
  - Assembly slot[fill] <= in_inst.
  - fill <= fill+1.
- Accept with completion (fill == cores-1 or in_last):
  - out_vliw <= assembly slots 0..fill-1, with slot[fill] = in_inst and slots above fill = NOP.
  - out_count <= fill+1; out_valid <= 1.
  - fill <= 0 and assembly slots reset to NOP.
- Latency: out_valid rises on the clock edge that accepts the completing instruction.
- Output drain: if out_valid && out_ready and no completion this cycle, out_valid <= 0. If a completion coincides with the drain, the new bundle replaces the old one and out_valid stays 1.
- While out_valid && !out_ready, out_vliw and out_count are held stable and in_ready=0.
- Throughput: 1 instruction/cycle and back-to-back bundles with no bubble while out_ready=1.
- in_last with fill=0: single-instruction bundle, out_count=1.
- cores=1: every accept completes; in_last is irrelevant.
- in_inst and in_last are ignored when there is no accept.

Optional Feature:
VLIW_PACKER_TIMEOUT_EN
- Defined:
  - An idle counter increments each cycle with fill>0 and no accept.
  - The counter clears on any accept or when fill=0.
  - When the counter reaches TIMEOUT and (!out_valid || out_ready), the partial bundle is emitted exactly as an in_last completion: NOP padding, out_count=fill.
  - Then fill <= 0 and the counter clears.
  - An accept in the same cycle takes priority, and the counter resets.
- Undefined: no idle counter; a partial bundle waits indefinitely for in_last or a full fill. TIMEOUT is unused.

Test Plan:
1. cores=4, inst_len=32, NOP=0, out_ready=1. Accept 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> after the 4th edge out_valid=1, out_vliw=0x00000044_00000033_00000022_00000011, out_count=4. out_valid drops the next cycle.
2. Accept 0xA, then 0xB with in_last=1 -> out_vliw=0x00000000_00000000_0000000B_0000000A, out_count=2.
3. Complete bundle X with out_ready=0 for 5 cycles -> out_vliw=X stable, in_ready=0 throughout. Raise out_ready while in_valid=1 -> X drains and 0x55 is accepted into slot 0 in the same cycle.
4. Accept 2 instructions, assert reset for 1 cycle -> out_valid=0, out_count=0. Then accept 0x1..0x4 -> out_vliw=0x00000004_00000003_00000002_00000001, no leftover slots.
5. 8 consecutive instructions 0x1..0x8 with out_ready=1 -> in_ready stays 1. Bundles 0x4_3_2_1 and 0x8_7_6_5 appear 4 cycles apart with no bubble.
6. With VLIW_PACKER_TIMEOUT_EN, TIMEOUT=8: accept 0x77, then idle -> 8 idle cycles later out_vliw=0x00000000_00000000_00000000_00000077, out_count=1. Without the macro, out_valid stays 0 for 50 cycles.

Source files
------------

// File: rtl/vliw_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vliw_packer: packs single instructions into CORES-slot VLIW bundles.       |
// | Optional partial-bundle flush: VLIW_PACKER_TIMEOUT_EN.  Revision: 1.0      |
// +----------------------------------------------------------------------------+
module vliw_packer #(
  parameter int                     CORES    = 4,
  parameter int                     INST_LEN = 32,
  parameter logic [INST_LEN-1:0]    NOP      = '0,
  parameter int                     TIMEOUT  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INST_LEN-1:0]           in_inst,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INST_LEN*CORES-1:0]     out_vliw,
  output logic [$clog2(CORES+1)-1:0]    out_count
);

  localparam int FW = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int CW = $clog2(CORES + 1);

  logic [INST_LEN-1:0]        r_slots [CORES];
  logic [FW-1:0]              r_fill;
  logic                       r_out_valid;
  logic [INST_LEN*CORES-1:0]  r_out_vliw;
  logic [CW-1:0]              r_out_count;

  logic                       w_in_ready;
  logic                       w_accept;
  logic                       w_full;
  logic                       w_complete;
  logic                       w_timeout;
  logic                       w_emit;
  logic [INST_LEN*CORES-1:0]  w_bundle;
  logic [CW-1:0]              w_count;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_full     = (r_fill == FW'(CORES - 1));
  assign w_complete = w_accept && (w_full || in_last);
  assign w_emit     = w_complete || w_timeout;
  assign w_count    = CW'(r_fill) + (w_accept ? CW'(1) : CW'(0));

  // Slots above fill already hold NOP, so only the slot at fill needs overlaying.
  for (genvar gi = 0; gi < CORES; gi++) begin : g_slot
    assign w_bundle[gi*INST_LEN +: INST_LEN] =
      (w_accept && (r_fill == FW'(gi))) ? in_inst : r_slots[gi];
  end

`ifdef VLIW_PACKER_TIMEOUT_EN
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [IW-1:0] r_idle;

  assign w_timeout = !w_accept && (r_fill != '0) && (r_idle == IW'(TIMEOUT)) && w_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle <= '0;
    end else if (w_accept || (r_fill == '0) || w_timeout) begin
      r_idle <= '0;
    end else if (r_idle != IW'(TIMEOUT)) begin
      r_idle <= r_idle + IW'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_out_vliw  <= {CORES{NOP}};
      r_out_count <= '0;
      for (int i = 0; i < CORES; i++) r_slots[i] <= NOP;
    end else if (w_emit) begin
      // A new bundle may replace one draining in the same cycle.
      r_out_vliw  <= w_bundle;
      r_out_count <= w_count;
      r_out_valid <= 1'b1;
      r_fill      <= '0;
      for (int i = 0; i < CORES; i++) r_slots[i] <= NOP;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_accept) begin
        r_slots[r_fill] <= in_inst;
        r_fill          <= r_fill + FW'(1);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_vliw  = r_out_vliw;
  assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_vliw_packer.sv
`default_nettype none
// Testbench for vliw_packer: table vectors, corner sequences and random traffic
// checked against a queue-based bundle model.
module tb_vliw_packer;

  localparam int CORES   = 4;
  localparam int ILEN    = 32;
  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_inst;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_vliw;
  logic [2:0]   out_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0]  cur[$];
  logic         m_valid;
  logic [127:0] m_vliw;
  logic [2:0]   m_count;
  int           m_idle;

  vliw_packer #(
    .CORES(CORES), .INST_LEN(ILEN), .NOP(32'h0), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_vliw(out_vliw), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [31:0]  inst;
    logic         last;
    logic         ordy;
    logic         exp_valid;
    logic         chk_data;
    logic [127:0] exp_vliw;
    logic [2:0]   exp_cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_cur();
    logic [127:0] r = '0;
    for (int i = 0; i < cur.size(); i++) r[i*32 +: 32] = cur[i];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cur.delete(); m_valid = 1'b0; m_vliw = '0; m_count = '0; m_idle = 0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_vliw", out_vliw, 128'h0);
    check("rst_out_count", out_count, 3'd0);
    check("rst_in_ready", in_ready, 1'b1);
  endtask

  task automatic cycle(input logic v, input logic [31:0] inst, input logic last, input logic ordy);
    logic exp_rdy, acc, drain, emit;
    @(negedge clk);
    in_valid = v; in_inst = inst; in_last = last; out_ready = ordy;
    #1;
    exp_rdy = !m_valid || ordy;
    check("in_ready", in_ready, exp_rdy);
    acc   = v && exp_rdy;
    drain = m_valid && ordy;
    emit  = 1'b0;
    @(posedge clk); #1;
    if (acc) begin
      cur.push_back(inst);
      m_idle = 0;
      if (cur.size() == CORES || last) emit = 1'b1;
    end else begin
`ifdef VLIW_PACKER_TIMEOUT_EN
      if (cur.size() > 0) begin
        if (m_idle == TIMEOUT && exp_rdy) emit = 1'b1;
        else if (m_idle < TIMEOUT) m_idle++;
      end else begin
        m_idle = 0;
      end
`endif
    end
    if (emit) begin
      m_vliw  = pack_cur();
      m_count = 3'(cur.size());
      m_valid = 1'b1;
      cur.delete();
      m_idle  = 0;
    end else if (drain) begin
      m_valid = 1'b0;
    end
    check("out_valid", out_valid, m_valid);
    check("out_vliw", out_vliw, m_vliw);
    check("out_count", out_count, m_count);
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] inst, input logic last,
                              input logic ordy, input logic ev, input logic cd,
                              input logic [127:0] evl, input logic [2:0] ec);
    vec_t t;
    t.v = v; t.inst = inst; t.last = last; t.ordy = ordy;
    t.exp_valid = ev; t.chk_data = cd; t.exp_vliw = evl; t.exp_cnt = ec;
    return t;
  endfunction

  initial begin
    logic [127:0] x;
    logic         seen;
    reset = 1'b0; in_valid = 1'b0; in_inst = '0; in_last = 1'b0; out_ready = 1'b1;
    m_valid = 1'b0; m_vliw = '0; m_count = '0; m_idle = 0;

    tbl[0]  = mk(1, 32'h11, 0, 1, 0, 0, 128'h0, 0);
    tbl[1]  = mk(1, 32'h22, 0, 1, 0, 0, 128'h0, 0);
    tbl[2]  = mk(1, 32'h33, 0, 1, 0, 0, 128'h0, 0);
    tbl[3]  = mk(1, 32'h44, 0, 1, 1, 1, 128'h00000044_00000033_00000022_00000011, 4);
    tbl[4]  = mk(0, 32'hDEAD, 1, 1, 0, 0, 128'h0, 0);
    tbl[5]  = mk(1, 32'hA, 0, 1, 0, 0, 128'h0, 0);
    tbl[6]  = mk(1, 32'hB, 1, 1, 1, 1, 128'h00000000_00000000_0000000B_0000000A, 2);
    tbl[7]  = mk(1, 32'h1, 0, 1, 0, 0, 128'h0, 0);
    tbl[8]  = mk(1, 32'h2, 1, 0, 1, 1, 128'h00000000_00000000_00000002_00000001, 2);
    tbl[9]  = mk(1, 32'h9, 1, 0, 1, 1, 128'h00000000_00000000_00000002_00000001, 2);
    tbl[10] = mk(1, 32'h55, 0, 1, 0, 0, 128'h0, 0);
    tbl[11] = mk(1, 32'h77, 1, 1, 1, 1, 128'h00000000_00000000_00000077_00000055, 2);
    tbl[12] = mk(1, 32'h99, 1, 1, 1, 1, 128'h00000000_00000000_00000000_00000099, 1);
    tbl[13] = mk(0, 32'h0, 0, 1, 0, 0, 128'h0, 0);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].v, tbl[i].inst, tbl[i].last, tbl[i].ordy);
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].exp_valid);
      if (tbl[i].chk_data) begin
        check($sformatf("tbl%0d_vliw", i), out_vliw, tbl[i].exp_vliw);
        check($sformatf("tbl%0d_count", i), out_count, tbl[i].exp_cnt);
      end
    end

    // Backpressure: bundle held for 5 stalled cycles, then drain plus accept.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 32'hC0 + 32'(i), 0, 0);
    x = 128'h000000C3_000000C2_000000C1_000000C0;
    check("t3_bundle", out_vliw, x);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 32'hEE, 1, 0);
      check("t3_hold_vliw", out_vliw, x);
      check("t3_hold_valid", out_valid, 1'b1);
    end
    cycle(1, 32'h55, 0, 1);
    check("t3_drained", out_valid, 1'b0);
    cycle(1, 32'h56, 1, 1);
    check("t3_slot0", out_vliw, 128'h00000000_00000000_00000056_00000055);

    // Reset mid-bundle discards the partial slots.
    do_reset();
    cycle(1, 32'hF1, 0, 1);
    cycle(1, 32'hF2, 0, 1);
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, 32'(i), 0, 1);
    check("t4_vliw", out_vliw, 128'h00000004_00000003_00000002_00000001);
    check("t4_count", out_count, 3'd4);

    // Back-to-back bundles with no bubble.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 32'(i), 0, 1);
      check("t5_valid", out_valid, (i == 4 || i == 8));
      if (i == 4) check("t5_b0", out_vliw, 128'h00000004_00000003_00000002_00000001);
      if (i == 8) check("t5_b1", out_vliw, 128'h00000008_00000007_00000006_00000005);
    end

    // Partial bundle left idle.
    do_reset();
    cycle(1, 32'h77, 0, 1);
    seen = 1'b0;
`ifdef VLIW_PACKER_TIMEOUT_EN
    for (int i = 0; i < 12; i++) begin
      cycle(0, 32'h0, 0, 1);
      if (out_valid) seen = 1'b1;
      if (out_valid) check("t6_vliw", out_vliw, 128'h00000000_00000000_00000000_00000077);
    end
    check("t6_flushed", seen, 1'b1);
`else
    for (int i = 0; i < 50; i++) begin
      cycle(0, 32'h0, 0, 1);
      if (out_valid) seen = 1'b1;
    end
    check("t6_no_flush", seen, 1'b0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
